// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM states,
// stall-vector encodings and counter limits.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Stall bit k freezes pipeline register k: [0] PC .. [4] MEM/WB
  localparam logic [4:0] STALL_NONE    = 5'b00000;
  localparam logic [4:0] STALL_IF      = 5'b00001;
  localparam logic [4:0] STALL_LOADUSE = 5'b00011;
  localparam logic [4:0] STALL_MEM     = 5'b01111;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages (master) and the stall controller (slave).
interface pipe_ctrl_if;

  logic        if_stallreq;
  logic        mem_stallreq;
  logic        id_re1;
  logic        id_re2;
  logic [4:0]  id_raddr1;
  logic [4:0]  id_raddr2;
  logic        ex_is_load;
  logic [4:0]  ex_waddr;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [4:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        new_pc_valid;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output if_stallreq, mem_stallreq, id_re1, id_re2, id_raddr1, id_raddr2,
           ex_is_load, ex_waddr, branch_flag, branch_target,
    input  stall, flush, new_pc, new_pc_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_stallreq, mem_stallreq, id_re1, id_re2, id_raddr1, id_raddr2,
           ex_is_load, ex_waddr, branch_flag, branch_target,
    output stall, flush, new_pc, new_pc_valid, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID operand that depends on a load still in EX.
module hazard_detect (
  input  logic       id_re1,
  input  logic       id_re2,
  input  logic [4:0] id_raddr1,
  input  logic [4:0] id_raddr2,
  input  logic       ex_is_load,
  input  logic [4:0] ex_waddr,
  output logic       load_use
);

  logic hit1;
  logic hit2;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hit1     = id_re1 && (id_raddr1 == ex_waddr);
  assign hit2     = id_re2 && (id_raddr2 == ex_waddr);
  assign load_use = ex_is_load && (ex_waddr != 5'd0) && (hit1 || hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: prioritises memory, branch, load-use and
// fetch hazards, and drains a wrong-path fetch that is still outstanding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic [4:0]  stall_o;
  logic        flush_o;
  logic        new_pc_valid_o;
  logic [31:0] new_pc_o;
  logic        load_use;

  hazard_detect u_hazard (
    .id_re1     (bus.id_re1),
    .id_re2     (bus.id_re2),
    .id_raddr1  (bus.id_raddr1),
    .id_raddr2  (bus.id_raddr2),
    .ex_is_load (bus.ex_is_load),
    .ex_waddr   (bus.ex_waddr),
    .load_use   (load_use)
  );

  // Outputs are gated by rst so they fall to zero the moment reset asserts
  always_comb begin
    state_d        = state_q;
    stall_o        = STALL_NONE;
    flush_o        = 1'b0;
    new_pc_valid_o = 1'b0;
    new_pc_o       = 32'd0;
    if (!rst) begin
      state_d = ST_RUN;
    end else if (bus.mem_stallreq) begin
      stall_o = STALL_MEM;
    end else if (state_q == ST_DRAIN) begin
      flush_o = 1'b1;
      stall_o = STALL_IF;
      if (!bus.if_stallreq) begin
        state_d = ST_RUN;
      end
    end else if (bus.branch_flag) begin
      flush_o        = 1'b1;
      new_pc_valid_o = 1'b1;
      new_pc_o       = bus.branch_target;
      if (bus.if_stallreq) begin
        state_d = ST_DRAIN;
      end
    end else if (load_use) begin
      stall_o = STALL_LOADUSE;
    end else if (bus.if_stallreq) begin
      stall_o = STALL_IF;
    end

    stall_cnt_d = stall_cnt_q;
    if ((stall_o != STALL_NONE) && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    flush_cnt_d = new_pc_valid_o ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall        = stall_o;
  assign bus.flush        = flush_o;
  assign bus.new_pc       = new_pc_o;
  assign bus.new_pc_valid = new_pc_valid_o;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model predicts each cycle's
// response, a negedge monitor compares what the controller presents.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ifs;
    logic        mems;
    logic        re1;
    logic        re2;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        ld;
    logic [4:0]  wa;
    logic        br;
    logic [31:0] tgt;
  } stim_t;

  typedef struct {
    logic [4:0]  stall;
    logic        flush;
    logic        npv;
    logic [31:0] npc;
    bit          cnt_known;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_vectors     = 0;
  int          n_miscompares = 0;

  // Reference model: a drain flag plus two plain counters
  bit          m_drain     = 1'b0;
  logic [31:0] m_stall_cnt = 32'd0;
  int          m_flush_cnt = 0;
  bit          cnt_known   = 1'b1;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, ifs: 1'b0, mems: 1'b0, re1: 1'b0, re2: 1'b0, ra1: 5'd0,
          ra2: 5'd0, ld: 1'b0, wa: 5'd0, br: 1'b0, tgt: 32'd0};
    return s;
  endfunction

  task automatic apply_stimulus(input stim_t s, input string tag);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    rst               = s.rst;
    bus.if_stallreq   = s.ifs;
    bus.mem_stallreq  = s.mems;
    bus.id_re1        = s.re1;
    bus.id_re2        = s.re2;
    bus.id_raddr1     = s.ra1;
    bus.id_raddr2     = s.ra2;
    bus.ex_is_load    = s.ld;
    bus.ex_waddr      = s.wa;
    bus.branch_flag   = s.br;
    bus.branch_target = s.tgt;

    e.stall     = 5'b00000;
    e.flush     = 1'b0;
    e.npv       = 1'b0;
    e.npc       = 32'd0;
    e.tag       = tag;
    if (!s.rst) begin
      m_drain     = 1'b0;
      m_stall_cnt = 32'd0;
      m_flush_cnt = 0;
      cnt_known   = 1'b1;
      e.cnt_known = 1'b1;
      e.stall_cnt = 32'd0;
      e.flush_cnt = 16'd0;
    end else begin
      e.cnt_known = cnt_known;
      e.stall_cnt = m_stall_cnt;
      e.flush_cnt = m_flush_cnt[15:0];
      lu = s.ld && (s.wa != 5'd0) &&
           ((s.re1 && s.ra1 == s.wa) || (s.re2 && s.ra2 == s.wa));
      if (s.mems) begin
        e.stall = 5'b01111;
      end else if (m_drain) begin
        e.flush = 1'b1;
        e.stall = 5'b00001;
        m_drain = s.ifs;
      end else if (s.br) begin
        e.flush = 1'b1;
        e.npv   = 1'b1;
        e.npc   = s.tgt;
        m_drain = s.ifs;
      end else if (lu) begin
        e.stall = 5'b00011;
      end else if (s.ifs) begin
        e.stall = 5'b00001;
      end
      if (e.stall != 5'd0 && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
      if (e.npv) m_flush_cnt = (m_flush_cnt + 1) % 65536;
    end
    sb_q.push_back(e);
  endtask

  task automatic check_field(input string tag, input string name,
                             input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_field(e.tag, "stall", 32'(bus.stall), 32'(e.stall));
    check_field(e.tag, "flush", 32'(bus.flush), 32'(e.flush));
    check_field(e.tag, "new_pc_valid", 32'(bus.new_pc_valid), 32'(e.npv));
    check_field(e.tag, "new_pc", bus.new_pc, e.npc);
    check_field(e.tag, "flush_cnt", 32'(bus.flush_cnt), 32'(e.flush_cnt));
    if (e.cnt_known) check_field(e.tag, "stall_cnt", bus.stall_cnt, e.stall_cnt);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_output(mon_e);
    end
  end

  initial begin
    stim_t s;
    bus.if_stallreq   = 1'b0;
    bus.mem_stallreq  = 1'b0;
    bus.id_re1        = 1'b0;
    bus.id_re2        = 1'b0;
    bus.id_raddr1     = 5'd0;
    bus.id_raddr2     = 5'd0;
    bus.ex_is_load    = 1'b0;
    bus.ex_waddr      = 5'd0;
    bus.branch_flag   = 1'b0;
    bus.branch_target = 32'd0;

    // Reset with hazards asserted: everything must stay quiet
    s = idle(); s.rst = 1'b0; s.br = 1'b1; s.tgt = 32'h40; s.mems = 1'b1;
    apply_stimulus(s, "reset");
    apply_stimulus(idle(), "idle");

    s = idle(); s.ld = 1'b1; s.wa = 5'd5; s.re1 = 1'b1; s.ra1 = 5'd5;
    apply_stimulus(s, "lu_rs1");
    s.wa = 5'd0; s.ra1 = 5'd0;
    apply_stimulus(s, "lu_r0");
    s = idle(); s.ld = 1'b1; s.wa = 5'd9; s.re2 = 1'b1; s.ra2 = 5'd9; s.ra1 = 5'd9;
    apply_stimulus(s, "lu_rs2");
    s.re2 = 1'b0;
    apply_stimulus(s, "lu_noread");

    s = idle(); s.br = 1'b1; s.tgt = 32'h100;
    apply_stimulus(s, "branch");
    s = idle(); s.ld = 1'b1; s.wa = 5'd5; s.re1 = 1'b1; s.ra1 = 5'd5;
    apply_stimulus(s, "after_branch");
    s.br = 1'b1; s.tgt = 32'h200;
    apply_stimulus(s, "branch_squash_lu");

    // Wrong-path fetch outstanding for three cycles, then drained
    s = idle(); s.br = 1'b1; s.ifs = 1'b1; s.tgt = 32'h300;
    apply_stimulus(s, "drain_enter");
    s.tgt = 32'h340; s.ld = 1'b1; s.wa = 5'd3; s.re1 = 1'b1; s.ra1 = 5'd3;
    apply_stimulus(s, "drain_ignore_br");
    s = idle(); s.ifs = 1'b1; s.mems = 1'b1;
    apply_stimulus(s, "drain_mem");
    s.mems = 1'b0;
    apply_stimulus(s, "drain_hold");
    apply_stimulus(idle(), "drain_exit");
    apply_stimulus(idle(), "drain_done");

    // Memory stall outranks branch and load-use for four cycles
    s = idle(); s.mems = 1'b1; s.br = 1'b1; s.tgt = 32'h500;
    s.ld = 1'b1; s.wa = 5'd7; s.re2 = 1'b1; s.ra2 = 5'd7;
    repeat (4) apply_stimulus(s, "mem_stall");
    s.mems = 1'b0;
    apply_stimulus(s, "mem_release");

    // Reset in the middle of a drain
    s = idle(); s.br = 1'b1; s.ifs = 1'b1; s.tgt = 32'h600;
    apply_stimulus(s, "rd_enter");
    s.rst = 1'b0;
    apply_stimulus(s, "rd_reset");
    s = idle(); s.ifs = 1'b1;
    apply_stimulus(s, "rd_after");
    apply_stimulus(idle(), "rd_idle");

    // Saturation: jump the counter close to its ceiling, then keep stalling
    @(negedge clk);
    #1;
    cnt_known = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    s = idle(); s.mems = 1'b1;
    apply_stimulus(s, "sat_force");
    release dut.stall_cnt_q;
    repeat (5) apply_stimulus(s, "sat_ramp");
    m_stall_cnt = 32'hFFFF_FFFF;
    cnt_known   = 1'b1;
    repeat (3) apply_stimulus(s, "sat_hold");
    s = idle(); s.ifs = 1'b1;
    apply_stimulus(s, "sat_if");

    for (int i = 0; i < 600; i++) begin
      s.rst  = ($urandom_range(0, 59) != 0);
      s.mems = ($urandom_range(0, 5) == 0);
      s.ifs  = ($urandom_range(0, 2) == 0);
      s.br   = ($urandom_range(0, 4) == 0);
      s.ld   = 1'($urandom_range(0, 1));
      s.re1  = 1'($urandom_range(0, 1));
      s.re2  = 1'($urandom_range(0, 1));
      s.wa   = 5'($urandom_range(0, 3));
      s.ra1  = 5'($urandom_range(0, 3));
      s.ra2  = 5'($urandom_range(0, 3));
      s.tgt  = $urandom;
      apply_stimulus(s, "random");
    end
    apply_stimulus(idle(), "final");

    repeat (3) @(negedge clk);
    #1;
    n_vectors++;
    if (sb_q.size() != 0) begin
      n_miscompares++;
      $display("[TB] FAIL drain_queue: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
